// File: rtl/ram_io_responder_pkg.sv
// rtl/ram_io_responder_pkg.sv - shared constants and I/O decode for the RAM/I/O responder
package ram_io_responder_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] IO_UART_ADDR = 32'h0003_0000;
    localparam logic [XLEN-1:0] IO_HALT_ADDR = 32'h0003_0004;
    localparam int              IO_SEL_HI    = 17;
    localparam int              IO_SEL_LO    = 16;

    typedef enum logic [1:0] {
        IO_NONE,
        IO_UART,
        IO_HALT
    } io_reg_e;

    function automatic io_reg_e io_decode(input logic [XLEN-1:0] addr);
        if (addr == IO_UART_ADDR) return IO_UART;
        if (addr == IO_HALT_ADDR) return IO_HALT;
        return IO_NONE;
    endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// rtl/ram_io_responder_if.sv - byte-serial memory bus between controller and responder
interface ram_io_responder_if;
    import ram_io_responder_pkg::*;

    logic [XLEN-1:0] mem_ram_addr;
    logic            mem_ram_wr;
    logic [7:0]      mem_ram_data;
    logic [7:0]      ram_data;
    logic            io_buffer_full;

    modport master (
        output mem_ram_addr, mem_ram_wr, mem_ram_data,
        input  ram_data, io_buffer_full
    );

    modport slave (
        input  mem_ram_addr, mem_ram_wr, mem_ram_data,
        output ram_data, io_buffer_full
    );

endinterface

// File: rtl/ram_io_responder_byte_fifo.sv
// rtl/ram_io_responder_byte_fifo.sv - power-of-two byte FIFO; a full FIFO still accepts a push paired with a pop
module ram_io_responder_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head_data,
    output logic [$clog2(DEPTH):0]     count_next,
    output logic                       full,
    output logic                       empty,
    output logic                       drop
);
    localparam int              PW       = $clog2(DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    logic [7:0]    store [0:DEPTH-1];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    always_comb begin
        full       = (count_q == FULL_CNT);
        empty      = (count_q == '0);
        pop_ok     = pop && !empty;
        push_ok    = push && (!full || pop_ok);
        drop       = push && !push_ok;
        head_d     = head_q + PW'(pop_ok);
        tail_d     = tail_q + PW'(push_ok);
        count_next = count_q;
        if (push_ok && !pop_ok)
            count_next = count_q + CW'(1);
        else if (pop_ok && !push_ok)
            count_next = count_q - CW'(1);
    end

    assign head_data = store[head_q];

    always_ff @(posedge clk) begin
        if (en) begin
            if (rst) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && push_ok)
            store[tail_q] <= push_data;
    end

endmodule

// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - serves controller bus cycles from byte RAM or memory-mapped UART/halt I/O
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    ram_io_responder_if.slave  bus,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               halt,
    output logic               tx_overflow
);
    localparam int            CW        = $clog2(TX_FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_MARK = CW'(TX_FIFO_DEPTH - 2);

    logic [7:0]            mem [0:2**ADDR_WIDTH-1];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  io_sel, wr;
    io_reg_e               io_reg;
    logic                  tx_push, tx_pop, tx_full, tx_empty, tx_drop;
    logic [CW-1:0]         tx_count_next;
    logic [7:0]            ram_rd_q, io_rdata_d, io_rdata_q;
    logic                  ram_sel_d, ram_sel_q;
    logic                  halt_d, halt_q, ovf_d, ovf_q, buf_full_d, buf_full_q;

    always_comb begin
        idx        = bus.mem_ram_addr[ADDR_WIDTH-1:0];
        wr         = bus.mem_ram_wr;
        io_sel     = (bus.mem_ram_addr[IO_SEL_HI:IO_SEL_LO] == 2'b11);
        io_reg     = io_decode(bus.mem_ram_addr);
        tx_push    = rdy && wr && io_sel && (io_reg == IO_UART);
        tx_pop     = rdy && tx_valid && tx_ready;
        rx_ready   = rdy && !wr && io_sel && (io_reg == IO_UART) && rx_valid;
        ram_sel_d  = !io_sel;
        halt_d     = halt_q || (wr && io_sel && (io_reg == IO_HALT));
        ovf_d      = ovf_q || tx_drop;
        // Two entries of slack: one cycle for the stall to land plus one byte already in flight.
        buf_full_d = (tx_count_next >= FULL_MARK);
        io_rdata_d = 8'h00;
        if (io_sel && !wr) begin
            case (io_reg)
                IO_UART: io_rdata_d = rx_valid ? rx_data : 8'h00;
                IO_HALT: io_rdata_d = {6'b0, tx_full, rx_valid};
                default: io_rdata_d = 8'h00;
            endcase
        end
    end

    // RAM is never reset; read-before-write falls out of the non-blocking read.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (wr && !io_sel)
                mem[idx] <= bus.mem_ram_data;
            ram_rd_q <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                ram_sel_q  <= 1'b0;
                io_rdata_q <= 8'h00;
                halt_q     <= 1'b0;
                ovf_q      <= 1'b0;
                buf_full_q <= 1'b0;
            end else begin
                ram_sel_q  <= ram_sel_d;
                io_rdata_q <= io_rdata_d;
                halt_q     <= halt_d;
                ovf_q      <= ovf_d;
                buf_full_q <= buf_full_d;
            end
        end
    end

    ram_io_responder_byte_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .en         (rdy),
        .push       (tx_push),
        .push_data  (bus.mem_ram_data),
        .pop        (tx_pop),
        .head_data  (tx_data),
        .count_next (tx_count_next),
        .full       (tx_full),
        .empty      (tx_empty),
        .drop       (tx_drop)
    );

    assign tx_valid           = !tx_empty;
    assign halt               = halt_q;
    assign tx_overflow        = ovf_q;
    assign bus.ram_data       = ram_sel_q ? ram_rd_q : io_rdata_q;
    assign bus.io_buffer_full = buf_full_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// tb/tb_ram_io_responder.sv - scoreboard bench for ram_io_responder
module tb_ram_io_responder;
    import ram_io_responder_pkg::*;

    typedef enum int {S_RAM, S_FULL, S_OVF, S_HALT, S_TXV, S_TXD, S_RXR} sig_e;
    typedef struct {
        int         due;
        sig_e       sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    logic       clk = 1'b0;
    logic       rst, rdy, tx_ready, rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid, rx_ready, halt, tx_overflow;
    logic [7:0] tx_data;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    ram_io_responder_if bus ();

    ram_io_responder #(.ADDR_WIDTH(17), .TX_FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .bus         (bus.slave),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .halt        (halt),
        .tx_overflow (tx_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input sig_e s);
        case (s)
            S_RAM:   return bus.ram_data;
            S_FULL:  return {7'b0, bus.io_buffer_full};
            S_OVF:   return {7'b0, tx_overflow};
            S_HALT:  return {7'b0, halt};
            S_TXV:   return {7'b0, tx_valid};
            S_TXD:   return tx_data;
            default: return {7'b0, rx_ready};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                logic [7:0] a;
                a = actual(sb[i].sel);
                checks++;
                if (sb[i].due < cyc) begin
                    errors++;
                    $display("FAIL %s: not sampled at cycle %0d", sb[i].name, sb[i].due);
                end else if (a !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s: got %02h expected %02h (cycle %0d)", sb[i].name, a, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [7:0] d);
        bus.mem_ram_addr = a;
        bus.mem_ram_wr   = w;
        bus.mem_ram_data = d;
    endtask

    task automatic expect_sig(input sig_e s, input logic [7:0] e, input int lat, input string n);
        exp_t x;
        x.due  = cyc + lat;
        x.sel  = s;
        x.exp  = e;
        x.name = n;
        sb.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img [4];
        logic [7:0] drain [8];
        img   = '{8'h93, 8'h85, 8'hC5, 8'h00};
        drain = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h20};

        rst = 1'b1; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        drive(32'h0, 1'b0, 8'h00);
        tick(); tick();
        rst = 1'b0;
        expect_sig(S_RAM,  8'h00, 0, "reset_ram_data");
        expect_sig(S_HALT, 8'h00, 0, "reset_halt");
        expect_sig(S_OVF,  8'h00, 0, "reset_overflow");
        expect_sig(S_FULL, 8'h00, 0, "reset_buf_full");
        expect_sig(S_TXV,  8'h00, 0, "reset_tx_valid");

        // RAM write then read, and read-before-write
        drive(32'h100, 1'b1, 8'hA5); tick();
        drive(32'h100, 1'b0, 8'h00); expect_sig(S_RAM, 8'hA5, 1, "ram_read_after_write"); tick();
        drive(32'h100, 1'b1, 8'h55); expect_sig(S_RAM, 8'hA5, 1, "rbw_old_a5"); tick();
        drive(32'h100, 1'b1, 8'hA5); expect_sig(S_RAM, 8'h55, 1, "rbw_old_55"); tick();
        drive(32'h100, 1'b0, 8'h00); expect_sig(S_RAM, 8'hA5, 1, "ram_restored"); tick();

        // Image word 0x00C58593, then back-to-back reads
        for (int i = 0; i < 4; i++) begin
            drive(32'(i), 1'b1, img[i]); tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(32'(i), 1'b0, 8'h00);
            expect_sig(S_RAM, img[i], 1, $sformatf("b2b_read_%0d", i));
            tick();
        end

        // Unmapped I/O write is ignored and returns zero
        drive(32'h30008, 1'b1, 8'hFF);
        expect_sig(S_RAM, 8'h00, 1, "io_other_wr_data");
        expect_sig(S_HALT, 8'h00, 1, "io_other_no_halt");
        tick();

        // Fill TX FIFO with tx_ready low
        tx_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            drive(IO_UART_ADDR, 1'b1, 8'(8'h10 + k));
            expect_sig(S_FULL, (k >= 6) ? 8'h01 : 8'h00, 1, $sformatf("buf_full_after_%0d", k));
            tick();
        end
        expect_sig(S_TXV, 8'h01, 0, "tx_valid_full");
        expect_sig(S_TXD, 8'h11, 0, "tx_head_full");

        // Push with simultaneous pop while full
        drive(IO_UART_ADDR, 1'b1, 8'h20); tx_ready = 1'b1;
        expect_sig(S_TXD, 8'h11, 0, "pushpop_head");
        expect_sig(S_OVF, 8'h00, 1, "pushpop_no_overflow");
        expect_sig(S_FULL, 8'h01, 1, "pushpop_still_full");
        tick();
        tx_ready = 1'b0;
        drive(IO_HALT_ADDR, 1'b0, 8'h00);
        expect_sig(S_RAM, 8'h02, 1, "status_full_bit");
        tick();
        drive(IO_UART_ADDR, 1'b1, 8'h99);
        expect_sig(S_OVF, 8'h01, 1, "overflow_on_9th");
        tick();

        // Drain in FIFO order; 0x99 was dropped
        drive(32'h0, 1'b0, 8'h00); tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_sig(S_TXV, 8'h01, 0, $sformatf("drain_valid_%0d", i));
            expect_sig(S_TXD, drain[i], 0, $sformatf("drain_data_%0d", i));
            tick();
        end
        expect_sig(S_TXV, 8'h00, 0, "drained_empty");
        tx_ready = 1'b0;

        // RX byte and status
        rx_valid = 1'b1; rx_data = 8'h41;
        drive(IO_UART_ADDR, 1'b0, 8'h00);
        expect_sig(S_RXR, 8'h01, 0, "rx_ready_pulse");
        expect_sig(S_RAM, 8'h41, 1, "rx_data_read");
        tick();
        drive(IO_HALT_ADDR, 1'b0, 8'h00);
        expect_sig(S_RXR, 8'h00, 0, "rx_ready_status_rd");
        expect_sig(S_RAM, 8'h01, 1, "status_rx_valid");
        tick();
        rx_valid = 1'b0;
        drive(IO_UART_ADDR, 1'b0, 8'h00);
        expect_sig(S_RXR, 8'h00, 0, "rx_ready_no_valid");
        expect_sig(S_RAM, 8'h00, 1, "rx_read_empty");
        tick();

        // rdy low freezes ram_data and suppresses rx_ready
        drive(32'h100, 1'b0, 8'h00); expect_sig(S_RAM, 8'hA5, 1, "pre_stall_read"); tick();
        rdy = 1'b0; rx_valid = 1'b1;
        drive(IO_UART_ADDR, 1'b0, 8'h00);
        expect_sig(S_RXR, 8'h00, 0, "stall_rx_ready");
        expect_sig(S_RAM, 8'hA5, 1, "stall_hold_data");
        tick();
        rdy = 1'b1; rx_valid = 1'b0;

        // Halt, then reset mid-drain
        drive(IO_HALT_ADDR, 1'b1, 8'h00);
        expect_sig(S_HALT, 8'h01, 1, "halt_set");
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(IO_UART_ADDR, 1'b1, 8'(8'h31 + k)); tick();
        end
        drive(32'h0, 1'b0, 8'h00); tx_ready = 1'b1;
        expect_sig(S_TXD, 8'h31, 0, "pre_reset_head");
        expect_sig(S_HALT, 8'h01, 0, "halt_sticky");
        tick();
        rst = 1'b1; tick();
        rst = 1'b0; tx_ready = 1'b0;
        expect_sig(S_TXV,  8'h00, 0, "rst_tx_valid");
        expect_sig(S_HALT, 8'h00, 0, "rst_halt");
        expect_sig(S_OVF,  8'h00, 0, "rst_overflow");
        expect_sig(S_FULL, 8'h00, 0, "rst_buf_full");
        expect_sig(S_RAM,  8'h00, 0, "rst_ram_data");
        drive(32'h100, 1'b0, 8'h00);
        expect_sig(S_RAM, 8'hA5, 1, "ram_survives_reset");
        tick();
        drive(32'h0, 1'b0, 8'h00);
        tick(); tick();

        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: never checked", sb[i].name);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
